// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: tracks the write register of each in-flight instruction and
// derives ALU-operand forwarding selects plus the load-use stall for the
// 5-stage MIPS pipeline. It sits beside the ID/EX pipeline latches.
//
// Ports
//   clk, reset         pipeline clock; asynchronous active-high reset
//   issue_valid        ID instruction advances into EX at next posedge
//   dest_in            write-register number of the issuing instruction
//   regwrite_in        issuing instruction writes the register file
//   memread_in         issuing instruction is a load
//   id_rs, id_rt       source registers of the instruction in ID
//   id_uses_rs/rt      ID instruction actually reads rs / rt
//   flush              kill the ID instruction (branch taken)
//   fwd_a, fwd_b       registered operand selects: 00 regfile, 10 EX/MEM, 01 MEM/WB
//   stall              combinational load-use stall (hold PC and IF/ID, insert bubble)
//   stall_count        saturating count of stall cycles
module fwd_hazard_unit #(
    parameter int unsigned REG_W = 5,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             issue_valid,
    input  logic [REG_W-1:0] dest_in,
    input  logic             regwrite_in,
    input  logic             memread_in,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             stall,
    output logic [CNT_W-1:0] stall_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_MEM = 2'b10;
    localparam logic [1:0] SEL_WB  = 2'b01;

    // The WB stage and the MEM-stage load flag are never consulted by any
    // select or by the stall, so only the EX and MEM fields that matter are kept.
    logic             ex_valid_q, ex_valid_d;
    logic [REG_W-1:0] ex_dest_q, ex_dest_d;
    logic             ex_regwrite_q, ex_regwrite_d;
    logic             ex_memread_q, ex_memread_d;
    logic             mem_valid_q, mem_valid_d;
    logic [REG_W-1:0] mem_dest_q, mem_dest_d;
    logic             mem_regwrite_q, mem_regwrite_d;
    logic [1:0]       fwd_a_q, fwd_a_d;
    logic [1:0]       fwd_b_q, fwd_b_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;

    logic ex_rs_hit, ex_rt_hit, mem_rs_hit, mem_rt_hit;
    logic stall_c, load_en;

    // Producer/consumer match; register $0 never matches.
    function automatic logic hit(input logic v, input logic rw,
                                 input logic [REG_W-1:0] d, input logic [REG_W-1:0] r,
                                 input logic used);
        return v & rw & (d != '0) & (d == r) & used;
    endfunction

    // Hazard detection and next-state computation.
    always_comb begin
        ex_rs_hit  = hit(ex_valid_q, ex_regwrite_q, ex_dest_q, id_rs, id_uses_rs);
        ex_rt_hit  = hit(ex_valid_q, ex_regwrite_q, ex_dest_q, id_rt, id_uses_rt);
        mem_rs_hit = hit(mem_valid_q, mem_regwrite_q, mem_dest_q, id_rs, id_uses_rs);
        mem_rt_hit = hit(mem_valid_q, mem_regwrite_q, mem_dest_q, id_rt, id_uses_rt);

        // Flush wins over a load-use hazard: the consumer is dead anyway.
        stall_c = !flush & ex_memread_q & (ex_rs_hit | ex_rt_hit);
        load_en = issue_valid & !stall_c & !flush;

        mem_valid_d    = ex_valid_q;
        mem_dest_d     = ex_dest_q;
        mem_regwrite_d = ex_regwrite_q;

        ex_valid_d    = 1'b0;
        ex_dest_d     = '0;
        ex_regwrite_d = 1'b0;
        ex_memread_d  = 1'b0;
        fwd_a_d       = SEL_RF;
        fwd_b_d       = SEL_RF;

        if (load_en) begin
            ex_valid_d    = 1'b1;
            ex_dest_d     = dest_in;
            ex_regwrite_d = regwrite_in;
            ex_memread_d  = memread_in;
            // Younger producer (current EX) takes priority over MEM.
            fwd_a_d = ex_rs_hit ? SEL_MEM : (mem_rs_hit ? SEL_WB : SEL_RF);
            fwd_b_d = ex_rt_hit ? SEL_MEM : (mem_rt_hit ? SEL_WB : SEL_RF);
        end

        stall_count_d = stall_count_q;
        if (stall_c && (stall_count_q != CNT_MAX)) begin
            stall_count_d = stall_count_q + CNT_W'(1);
        end
    end

    // Pipeline tracking state and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid_q     <= 1'b0;
            ex_dest_q      <= '0;
            ex_regwrite_q  <= 1'b0;
            ex_memread_q   <= 1'b0;
            mem_valid_q    <= 1'b0;
            mem_dest_q     <= '0;
            mem_regwrite_q <= 1'b0;
            fwd_a_q        <= SEL_RF;
            fwd_b_q        <= SEL_RF;
            stall_count_q  <= '0;
        end else begin
            ex_valid_q     <= ex_valid_d;
            ex_dest_q      <= ex_dest_d;
            ex_regwrite_q  <= ex_regwrite_d;
            ex_memread_q   <= ex_memread_d;
            mem_valid_q    <= mem_valid_d;
            mem_dest_q     <= mem_dest_d;
            mem_regwrite_q <= mem_regwrite_d;
            fwd_a_q        <= fwd_a_d;
            fwd_b_q        <= fwd_b_d;
            stall_count_q  <= stall_count_d;
        end
    end

    assign fwd_a       = fwd_a_q;
    assign fwd_b       = fwd_b_q;
    assign stall       = stall_c;
    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit. A narrow stall counter is used so
// saturation is reachable in a short run.
module tb_fwd_hazard_unit;

    localparam int unsigned REG_W = 5;
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CMAX = {CNT_W{1'b1}};

    logic             clk = 1'b0;
    logic             reset;
    logic             issue_valid;
    logic [REG_W-1:0] dest_in;
    logic             regwrite_in;
    logic             memread_in;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_uses_rs;
    logic             id_uses_rt;
    logic             flush;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic             stall;
    logic [CNT_W-1:0] stall_count;

    fwd_hazard_unit #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .issue_valid (issue_valid),
        .dest_in     (dest_in),
        .regwrite_in (regwrite_in),
        .memread_in  (memread_in),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rs  (id_uses_rs),
        .id_uses_rt  (id_uses_rt),
        .flush       (flush),
        .fwd_a       (fwd_a),
        .fwd_b       (fwd_b),
        .stall       (stall),
        .stall_count (stall_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] a;
        logic [1:0] b;
    } exp_t;

    exp_t             sb[$];
    logic [CNT_W-1:0] exp_cnt;
    int               n_vec = 0;
    int               n_err = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One pipeline cycle: drive the ID instruction, check the combinational
    // stall, queue the expected selects, clock, then retire the oldest entry.
    task automatic cyc(input string tag, input logic v, input logic [REG_W-1:0] d,
                       input logic rw, input logic mr,
                       input logic [REG_W-1:0] rs, input logic [REG_W-1:0] rt,
                       input logic urs, input logic urt, input logic fl,
                       input logic es, input logic [1:0] ea, input logic [1:0] eb);
        exp_t e;
        issue_valid = v;  dest_in = d;  regwrite_in = rw;  memread_in = mr;
        id_rs = rs;  id_rt = rt;  id_uses_rs = urs;  id_uses_rt = urt;  flush = fl;
        #1;
        chk({tag, ".stall"}, 16'(stall), 16'(es));
        sb.push_back('{a: ea, b: eb});
        if (es && exp_cnt != CMAX) exp_cnt = exp_cnt + CNT_W'(1);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $error("FAIL %s.sb: observed empty expected entry", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, ".fwd_a"}, 16'(fwd_a), 16'(e.a));
            chk({tag, ".fwd_b"}, 16'(fwd_b), 16'(e.b));
        end
        chk({tag, ".cnt"}, 16'(stall_count), 16'(exp_cnt));
    endtask

    initial begin
        reset = 1'b1;  issue_valid = 1'b0;  dest_in = '0;  regwrite_in = 1'b0;
        memread_in = 1'b0;  id_rs = '0;  id_rt = '0;  id_uses_rs = 1'b0;
        id_uses_rt = 1'b0;  flush = 1'b0;  exp_cnt = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.fwd_a", 16'(fwd_a), 16'h0);
        chk("rst.fwd_b", 16'(fwd_b), 16'h0);
        chk("rst.stall", 16'(stall), 16'h0);
        chk("rst.cnt",   16'(stall_count), 16'h0);
        reset = 1'b0;

        // Back-to-back ALU dependency on rs.
        cyc("b2b.p", 1, 5'd5,  1, 0, 5'd0, 5'd0, 0, 0, 0, 0, 2'b00, 2'b00);
        cyc("b2b.c", 1, 5'd6,  1, 0, 5'd5, 5'd7, 1, 1, 0, 0, 2'b10, 2'b00);

        // Distance-2 dependency on rt, then the same shape through $0.
        cyc("d2.p",  1, 5'd8,  1, 0, 5'd0, 5'd0, 0, 0, 0, 0, 2'b00, 2'b00);
        cyc("d2.i",  1, 5'd10, 1, 0, 5'd0, 5'd0, 0, 0, 0, 0, 2'b00, 2'b00);
        cyc("d2.c",  1, 5'd11, 1, 0, 5'd0, 5'd8, 0, 1, 0, 0, 2'b00, 2'b01);
        cyc("z.p",   1, 5'd0,  1, 0, 5'd0, 5'd0, 0, 0, 0, 0, 2'b00, 2'b00);
        cyc("z.i",   1, 5'd12, 1, 0, 5'd0, 5'd0, 0, 0, 0, 0, 2'b00, 2'b00);
        cyc("z.c",   1, 5'd13, 1, 0, 5'd0, 5'd0, 1, 1, 0, 0, 2'b00, 2'b00);

        // Two producers of r3: the younger one wins.
        cyc("dp.o",  1, 5'd3,  1, 0, 5'd0, 5'd0, 0, 0, 0, 0, 2'b00, 2'b00);
        cyc("dp.y",  1, 5'd3,  1, 0, 5'd0, 5'd0, 0, 0, 0, 0, 2'b00, 2'b00);
        cyc("dp.c",  1, 5'd14, 1, 0, 5'd3, 5'd0, 1, 0, 0, 0, 2'b10, 2'b00);

        // A non-writing producer never forwards.
        cyc("nw.p",  1, 5'd4,  0, 0, 5'd0, 5'd0, 0, 0, 0, 0, 2'b00, 2'b00);
        cyc("nw.c",  1, 5'd16, 1, 0, 5'd4, 5'd4, 1, 1, 0, 0, 2'b00, 2'b00);

        // Load-use: one stall cycle, then the consumer issues from MEM/WB.
        cyc("lu.ld", 1, 5'd9,  1, 1, 5'd0, 5'd0, 0, 0, 0, 0, 2'b00, 2'b00);
        cyc("lu.st", 1, 5'd15, 1, 0, 5'd0, 5'd9, 0, 1, 0, 1, 2'b00, 2'b00);
        cyc("lu.is", 1, 5'd15, 1, 0, 5'd0, 5'd9, 0, 1, 0, 0, 2'b00, 2'b01);

        // Flush during a load-use hazard: no stall, bubble, counter held.
        cyc("fl.ld", 1, 5'd9,  1, 1, 5'd0, 5'd0, 0, 0, 0, 0, 2'b00, 2'b00);
        cyc("fl.fl", 1, 5'd15, 1, 0, 5'd0, 5'd9, 0, 1, 1, 0, 2'b00, 2'b00);
        cyc("fl.nx", 1, 5'd17, 1, 0, 5'd9, 5'd0, 1, 0, 0, 0, 2'b01, 2'b00);

        // Drive the counter to all-ones and past it.
        for (int i = 0; i < 16; i++) begin
            cyc("sat.ld", 1, 5'd9,  1, 1, 5'd0, 5'd0, 0, 0, 0, 0, 2'b00, 2'b00);
            cyc("sat.st", 1, 5'd15, 1, 0, 5'd9, 5'd0, 1, 0, 0, 1, 2'b00, 2'b00);
            cyc("sat.is", 1, 5'd15, 1, 0, 5'd9, 5'd0, 1, 0, 0, 0, 2'b01, 2'b00);
        end
        chk("sat.final", 16'(stall_count), 16'(CMAX));

        // Asynchronous reset with live stages and a pending stall.
        cyc("ar.p",  1, 5'd20, 1, 0, 5'd0,  5'd0, 0, 0, 0, 0, 2'b00, 2'b00);
        cyc("ar.ld", 1, 5'd21, 1, 1, 5'd20, 5'd0, 1, 0, 0, 0, 2'b10, 2'b00);
        id_rs = 5'd0;  id_rt = 5'd21;  id_uses_rs = 1'b0;  id_uses_rt = 1'b1;
        #1;
        chk("ar.pre_stall", 16'(stall), 16'h1);
        reset = 1'b1;
        #1;
        chk("ar.fwd_a", 16'(fwd_a), 16'h0);
        chk("ar.fwd_b", 16'(fwd_b), 16'h0);
        chk("ar.stall", 16'(stall), 16'h0);
        chk("ar.cnt",   16'(stall_count), 16'h0);
        exp_cnt = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;

        // First edge after release loads normally.
        cyc("pr.p",  1, 5'd5,  1, 0, 5'd0, 5'd0, 0, 0, 0, 0, 2'b00, 2'b00);
        cyc("pr.c",  1, 5'd6,  1, 0, 5'd0, 5'd5, 0, 1, 0, 0, 2'b00, 2'b10);
        cyc("pr.d",  0, 5'd7,  1, 0, 5'd6, 5'd5, 1, 1, 0, 0, 2'b00, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
